// File: rtl/inst_fetch_if.sv
// Instruction fetch responder: turns pc/ce requests into req/ack bus reads and
// hands the instruction and its pc to IF/ID, stalling the PC while a fetch is outstanding.
module inst_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              stallreq_o,
  output logic              fetch_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  // The abort fires on the edge that would bring the counter to TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        to_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[5:2], stall_i[0]};
  assign mem_addr_o   = addr_q;

  // Released in the ack cycle so the PC advances on the same edge the data lands.
  assign stallreq_o = ce_i & ((state == IDLE) | ((state == REQ) & ~mem_ack_i) |
                              (state == DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= 8'd0;
      addr_q       <= '0;
      mem_req_o    <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
    end else begin
      fetch_err_o <= 1'b0;
      case (state)
        IDLE: begin
          inst_valid_o <= 1'b0;
          inst_o       <= '0;
          if (!flush_i && ce_i) begin
            if (pc_i[1:0] == 2'b00) begin
              addr_q    <= pc_i;
              mem_req_o <= 1'b1;
              to_cnt    <= 8'd0;
              state     <= REQ;
            end else begin
              inst_pc_o    <= pc_i;
              inst_valid_o <= 1'b1;
              fetch_err_o  <= 1'b1;
            end
          end
        end
        // DRAIN shares the REQ bus handling but never delivers data.
        REQ, DRAIN: begin
          inst_valid_o <= 1'b0;
          inst_o       <= '0;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            if (state == REQ && !flush_i) begin
              inst_o       <= mem_rdata_i;
              inst_pc_o    <= addr_q;
              inst_valid_o <= 1'b1;
              if (stall_i[1]) state <= HOLD;
            end
          end else if (to_cnt == TO_LAST) begin
            mem_req_o   <= 1'b0;
            state       <= IDLE;
            fetch_err_o <= 1'b1;
            if (state == REQ && !flush_i) begin
              inst_pc_o    <= addr_q;
              inst_valid_o <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + 8'd1;
            if (state == REQ && flush_i) state <= DRAIN;
          end
        end
        HOLD: begin
          if (flush_i || !stall_i[1]) begin
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_if.sv
// Directed bench for inst_fetch_if: basic fetch, slow ack, stall hold, flush,
// misaligned pc, bus timeout and reset mid-request.
module tb_inst_fetch_if;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic        fetch_err_o;

  int checks   = 0;
  int failures = 0;
  int req_cycles;

  inst_fetch_if dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o),
    .fetch_err_o  (fetch_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 ns after a rising edge and settle before any check.
  task automatic applyStimulus(input logic ce, input logic [31:0] pc, input logic st1,
                               input logic fl, input logic ack, input logic [31:0] rd);
    ce_i        = ce;
    pc_i        = pc;
    stall_i     = {4'b0000, st1, 1'b0};
    flush_i     = fl;
    mem_ack_i   = ack;
    mem_rdata_i = rd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("rst_req",   32'(mem_req_o),    32'd0);
    checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
    checkOutput("rst_inst",  inst_o,            32'h0);
    checkOutput("rst_err",   32'(fetch_err_o),  32'd0);
    checkOutput("rst_stall", 32'(stallreq_o),   32'd0);
    rst = 1'b0;
    step();

    // basic fetch, ack one cycle after the request rises
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b_stall0", 32'(stallreq_o), 32'd1);
    checkOutput("b_req0",   32'(mem_req_o),  32'd0);
    step();
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b_req1",   32'(mem_req_o),  32'd1);
    checkOutput("b_addr1",  mem_addr_o,      32'h0);
    checkOutput("b_stall1", 32'(stallreq_o), 32'd1);
    step();
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h24020005);
    checkOutput("b_stall2", 32'(stallreq_o), 32'd0);
    step();
    applyStimulus(1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b_valid", 32'(inst_valid_o), 32'd1);
    checkOutput("b_inst",  inst_o,            32'h24020005);
    checkOutput("b_pc",    inst_pc_o,         32'h0);
    checkOutput("b_req3",  32'(mem_req_o),    32'd0);
    step();
    checkOutput("b_valid_off", 32'(inst_valid_o), 32'd0);
    checkOutput("b_inst_off",  inst_o,            32'h0);

    // slow ack at pc 0x4; pc_i wanders but the latched address must not
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("s_addr",  mem_addr_o,      32'h4);
      checkOutput("s_req",   32'(mem_req_o),  32'd1);
      checkOutput("s_stall", 32'(stallreq_o), 32'd1);
      step();
    end
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("s_addr_ack",  mem_addr_o,      32'h4);
    checkOutput("s_stall_ack", 32'(stallreq_o), 32'd0);
    step();
    applyStimulus(1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s_inst",  inst_o,            32'hDEADBEEF);
    checkOutput("s_pc",    inst_pc_o,         32'h4);
    checkOutput("s_valid", 32'(inst_valid_o), 32'd1);
    step();
    checkOutput("s_valid_off", 32'(inst_valid_o), 32'd0);

    // ack while IF/ID is stalled for three cycles
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 32'h11112222);
    step();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("h_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("h_inst",  inst_o,            32'h11112222);
      checkOutput("h_pc",    inst_pc_o,         32'h8);
      step();
    end
    applyStimulus(1'b0, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("h_valid_last", 32'(inst_valid_o), 32'd1);
    checkOutput("h_inst_last",  inst_o,            32'h11112222);
    step();
    checkOutput("h_valid_off", 32'(inst_valid_o), 32'd0);
    checkOutput("h_inst_off",  inst_o,            32'h0);

    // flush during the request, late ack drained, then fetch at the new pc
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_req_drain", 32'(mem_req_o),    32'd1);
    checkOutput("f_valid_dr",  32'(inst_valid_o), 32'd0);
    step();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h00000055);
    checkOutput("f_stall_dr",  32'(stallreq_o), 32'd1);
    step();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_no_valid", 32'(inst_valid_o), 32'd0);
    checkOutput("f_inst_nop", inst_o,            32'h0);
    checkOutput("f_req_off",  32'(mem_req_o),    32'd0);
    step();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h00000066);
    checkOutput("f_new_addr", mem_addr_o,     32'h40);
    checkOutput("f_new_req",  32'(mem_req_o), 32'd1);
    step();
    applyStimulus(1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_new_inst",  inst_o,            32'h66);
    checkOutput("f_new_pc",    inst_pc_o,         32'h40);
    checkOutput("f_new_valid", 32'(inst_valid_o), 32'd1);
    step();

    // misaligned pc: error pulse, no bus access
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("m_req",   32'(mem_req_o),    32'd0);
    checkOutput("m_err",   32'(fetch_err_o),  32'd1);
    checkOutput("m_valid", 32'(inst_valid_o), 32'd1);
    checkOutput("m_inst",  inst_o,            32'h0);
    checkOutput("m_pc",    inst_pc_o,         32'h6);
    step();
    checkOutput("m_err_off", 32'(fetch_err_o), 32'd0);

    // no ack at all: the request must be withdrawn after exactly 255 cycles
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (!mem_req_o) break;
      req_cycles++;
      step();
    end
    checkOutput("t_req_cycles", 32'(req_cycles),      32'd255);
    checkOutput("t_err",        32'(fetch_err_o),     32'd1);
    checkOutput("t_valid",      32'(inst_valid_o),    32'd1);
    checkOutput("t_inst",       inst_o,               32'h0);
    checkOutput("t_pc",         inst_pc_o,            32'h20);
    step();
    checkOutput("t_err_off",    32'(fetch_err_o),     32'd0);
    checkOutput("t_valid_off",  32'(inst_valid_o),    32'd0);

    // reset mid-request drops the request at once; a late ack is ignored
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("r_req_before", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("r_req_async", 32'(mem_req_o), 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h30, 1'b0, 1'b0, 1'b1, 32'h77777777);
    step();
    applyStimulus(1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("r_late_ack", 32'(inst_valid_o), 32'd0);
    checkOutput("r_late_req", 32'(mem_req_o),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
